// File: rtl/hex_scroll_ctrl.sv
// ---------------------------------------------------------------------------
// hex_scroll_ctrl
//
// Scrolling message controller for a six-digit seven-segment display.
// A 16-entry nibble buffer holds the message. In RUN, a six-digit window
// slides across the message, one position per step. One step happens every
// (rate_sel+1) base ticks, and one base tick happens every TICK_DIV clocks.
// A message of six nibbles or fewer is shown left-justified and does not move.
//
// Ports
//   clk        : system clock, all state changes on the rising edge
//   reset      : synchronous active-high reset, highest priority
//   wr_en      : write wr_data into buffer[wr_addr] (accepted in any state)
//   wr_addr    : buffer write index (4 bits)
//   wr_data    : nibble to store (4 bits)
//   len        : message length 1..16, sampled when start is accepted
//   rate_sel   : step interval of (rate_sel+1) base ticks, sampled on start
//   start      : begin scrolling (accepted only in IDLE with a legal len)
//   stop       : return to IDLE (wins over start)
//   pause      : toggle between RUN and PAUSE
//   busy       : high while in RUN or PAUSE
//   d0..d5     : nibble for HEX0..HEX5 (HEX5 is the leftmost digit)
//   blank      : bit k high blanks HEXk
//   wrap_pulse : one-cycle pulse after the window position returns to 0
//
// All outputs come straight from registers.
// ---------------------------------------------------------------------------

// Runtime invariants of the scroll controller, kept apart from the datapath.
module hex_scroll_ctrl_chk (
    input  logic       clk,
    input  logic       reset,
    input  logic       busy,
    input  logic       wrap_pulse,
    input  logic [3:0] pos,
    input  logic [4:0] len
);

    // A wrap can only be reported while a scroll is active.
    a_wrap_busy: assert property (@(posedge clk) disable iff (reset)
        wrap_pulse |-> busy);

    // In scrolling mode the window position is always inside the message.
    a_pos_range: assert property (@(posedge clk) disable iff (reset)
        (busy && (len > 5'd6)) |-> ({1'b0, pos} < len));

    // A short message never moves.
    a_static_pos: assert property (@(posedge clk) disable iff (reset)
        (busy && (len <= 5'd6)) |-> (pos == 4'd0));

endmodule

module hex_scroll_ctrl #(
    parameter int TICK_DIV = 25000000,
    parameter int DEPTH    = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       wr_en,
    input  logic [3:0] wr_addr,
    input  logic [3:0] wr_data,
    input  logic [4:0] len,
    input  logic [1:0] rate_sel,
    input  logic       start,
    input  logic       stop,
    input  logic       pause,
    output logic       busy,
    output logic [3:0] d0,
    output logic [3:0] d1,
    output logic [3:0] d2,
    output logic [3:0] d3,
    output logic [3:0] d4,
    output logic [3:0] d5,
    output logic [5:0] blank,
    output logic       wrap_pulse
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2
    } state_t;

    state_t                 state_r;
    state_t                 state_nxt;
    logic [DEPTH-1:0][3:0]  buf_r;
    logic [4:0]             len_r;
    logic [4:0]             len_nxt;
    logic [1:0]             rate_r;
    logic [1:0]             rate_nxt;
    logic [3:0]             pos_r;
    logic [3:0]             pos_nxt;
    logic [PW-1:0]          presc_r;
    logic [PW-1:0]          presc_nxt;
    logic [1:0]             tick_r;
    logic [1:0]             tick_nxt;
    logic                   wrap_nxt;
    logic                   len_ok_s;
    logic                   start_ok_s;
    logic                   base_tick_s;
    logic                   step_s;
    logic [5:0][3:0]        disp_s;
    logic [5:0]             blank_s;
    logic [5:0][3:0]        d_r;
    logic [5:0]             blank_r;
    logic                   busy_r;
    logic                   wrap_r;

    // Returns {blank, nibble} for digit k given the window position and
    // message length. For long messages the window index wraps around the
    // message; since pos < len and the offset is at most 5 while len > 6,
    // a single conditional subtraction is a full modulo.
    function automatic logic [4:0] disp_nibble(
        input logic [DEPTH-1:0][3:0] b,
        input logic [3:0]            p,
        input logic [4:0]            ln,
        input logic [2:0]            k
    );
        logic [4:0] off;
        logic [4:0] idx;
        logic [4:0] res;
        off = 5'd5 - {2'b00, k};
        idx = {1'b0, p} + off;
        if (ln > 5'd6) begin
            if (idx >= ln) begin
                idx = idx - ln;
            end else begin
                idx = idx;
            end
            res = {1'b0, b[idx[3:0]]};
        end else if (off < ln) begin
            res = {1'b0, b[off[3:0]]};
        end else begin
            res = {1'b1, 4'h0};
        end
        return res;
    endfunction

    assign len_ok_s = (len != 5'd0) && (len <= 5'd16);

    // Next-state logic: stop beats start and pause, start only from IDLE.
    always_comb begin
        state_nxt  = state_r;
        start_ok_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start && !stop && len_ok_s) begin
                    state_nxt  = ST_RUN;
                    start_ok_s = 1'b1;
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (stop) begin
                    state_nxt = ST_IDLE;
                end else if (pause) begin
                    state_nxt = ST_PAUSE;
                end else begin
                    state_nxt = ST_RUN;
                end
            end
            ST_PAUSE: begin
                if (stop) begin
                    state_nxt = ST_IDLE;
                end else if (pause) begin
                    state_nxt = ST_RUN;
                end else begin
                    state_nxt = ST_PAUSE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Prescaler, base-tick counter and window position update.
    always_comb begin
        len_nxt     = len_r;
        rate_nxt    = rate_r;
        pos_nxt     = pos_r;
        presc_nxt   = presc_r;
        tick_nxt    = tick_r;
        wrap_nxt    = 1'b0;
        base_tick_s = 1'b0;
        step_s      = 1'b0;
        if (start_ok_s) begin
            len_nxt   = len;
            rate_nxt  = rate_sel;
            pos_nxt   = 4'd0;
            presc_nxt = '0;
            tick_nxt  = 2'd0;
        end else if (state_r == ST_RUN) begin
            base_tick_s = (presc_r == PRESC_MAX);
            if (base_tick_s) begin
                presc_nxt = '0;
                if (tick_r == rate_r) begin
                    tick_nxt = 2'd0;
                    step_s   = 1'b1;
                end else begin
                    tick_nxt = tick_r + 2'd1;
                end
            end else begin
                presc_nxt = presc_r + PW'(1);
            end
            // Short messages are static: the step is swallowed.
            if (step_s && (len_r > 5'd6)) begin
                if ({1'b0, pos_r} == (len_r - 5'd1)) begin
                    pos_nxt  = 4'd0;
                    // A stop in the same cycle ends the scroll silently.
                    wrap_nxt = (state_nxt != ST_IDLE);
                end else begin
                    pos_nxt = pos_r + 4'd1;
                end
            end else begin
                pos_nxt = pos_r;
            end
        end else begin
            pos_nxt = pos_r;
        end
    end

    // Display image for the coming cycle, read from the buffer before any
    // same-cycle write lands.
    always_comb begin
        disp_s  = '0;
        blank_s = '0;
        for (int k = 0; k < 6; k++) begin
            {blank_s[k], disp_s[k]} = disp_nibble(buf_r, pos_nxt, len_nxt, 3'(k));
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt;
        end
    end

    // Scroll datapath registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            len_r   <= 5'd0;
            rate_r  <= 2'd0;
            pos_r   <= 4'd0;
            presc_r <= '0;
            tick_r  <= 2'd0;
        end else begin
            len_r   <= len_nxt;
            rate_r  <= rate_nxt;
            pos_r   <= pos_nxt;
            presc_r <= presc_nxt;
            tick_r  <= tick_nxt;
        end
    end

    // Message buffer, writable in every state.
    always_ff @(posedge clk) begin
        if (reset) begin
            buf_r <= '0;
        end else if (wr_en) begin
            buf_r[wr_addr] <= wr_data;
        end else begin
            buf_r <= buf_r;
        end
    end

    // Output registers: idle image, live image in RUN, frozen image in PAUSE.
    always_ff @(posedge clk) begin
        if (reset) begin
            d_r     <= '0;
            blank_r <= 6'h3F;
            busy_r  <= 1'b0;
            wrap_r  <= 1'b0;
        end else begin
            wrap_r <= wrap_nxt;
            if (state_nxt == ST_IDLE) begin
                d_r     <= '0;
                blank_r <= 6'h3F;
                busy_r  <= 1'b0;
            end else if (state_r != ST_PAUSE) begin
                d_r     <= disp_s;
                blank_r <= blank_s;
                busy_r  <= 1'b1;
            end else begin
                d_r     <= d_r;
                blank_r <= blank_r;
                busy_r  <= 1'b1;
            end
        end
    end

    assign busy       = busy_r;
    assign blank      = blank_r;
    assign wrap_pulse = wrap_r;
    assign d0         = d_r[0];
    assign d1         = d_r[1];
    assign d2         = d_r[2];
    assign d3         = d_r[3];
    assign d4         = d_r[4];
    assign d5         = d_r[5];

    hex_scroll_ctrl_chk u_chk (
        .clk        (clk),
        .reset      (reset),
        .busy       (busy_r),
        .wrap_pulse (wrap_r),
        .pos        (pos_r),
        .len        (len_r)
    );

endmodule

// File: tb/tb_hex_scroll_ctrl.sv
// ---------------------------------------------------------------------------
// tb_hex_scroll_ctrl
//
// Directed scenarios followed by randomized traffic. A reference model,
// written in terms of elapsed RUN cycles and modulo arithmetic, predicts
// the registered outputs for every cycle and queues them; a monitor pops
// and compares on the falling edge.
// ---------------------------------------------------------------------------
module tb_hex_scroll_ctrl;

    localparam int TD = 4;

    logic       clk;
    logic       reset;
    logic       wr_en;
    logic [3:0] wr_addr;
    logic [3:0] wr_data;
    logic [4:0] len;
    logic [1:0] rate_sel;
    logic       start;
    logic       stop;
    logic       pause;
    logic       busy;
    logic [3:0] d0, d1, d2, d3, d4, d5;
    logic [5:0] blank;
    logic       wrap_pulse;
    logic [23:0] dig;

    assign dig = {d5, d4, d3, d2, d1, d0};

    hex_scroll_ctrl #(.TICK_DIV(TD), .DEPTH(16)) dut (
        .clk        (clk),
        .reset      (reset),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .len        (len),
        .rate_sel   (rate_sel),
        .start      (start),
        .stop       (stop),
        .pause      (pause),
        .busy       (busy),
        .d0         (d0),
        .d1         (d1),
        .d2         (d2),
        .d3         (d3),
        .d4         (d4),
        .d5         (d5),
        .blank      (blank),
        .wrap_pulse (wrap_pulse)
    );

    typedef struct packed {
        logic        busy;
        logic [5:0]  blank;
        logic [23:0] dig;
        logic        wrap;
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;
    int   wraps_seen = 0;

    // reference model state
    int         m_state = 0;   // 0 idle, 1 run, 2 pause
    logic [3:0] m_buf[16];
    int         m_len = 0;
    int         m_rate = 0;
    int         m_pos = 0;
    int         m_run = 0;
    logic [23:0] m_disp = 24'h0;
    logic [5:0]  m_blank = 6'h3F;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        exp_t e;
        logic upd;
        logic w;
        int   idx;
        upd = 1'b0;
        w   = 1'b0;
        if (reset) begin
            m_state = 0;
            for (int i = 0; i < 16; i++) m_buf[i] = 4'h0;
            m_len = 0; m_rate = 0; m_pos = 0; m_run = 0;
            m_disp = 24'h0; m_blank = 6'h3F;
        end else begin
            case (m_state)
                0: if (start && !stop && len >= 5'd1 && len <= 5'd16) begin
                    m_len = int'(len); m_rate = int'(rate_sel);
                    m_pos = 0; m_run = 0; m_state = 1; upd = 1'b1;
                end
                1: begin
                    m_run++;
                    upd = 1'b1;
                    if ((m_run % (TD * (m_rate + 1))) == 0 && m_len > 6) begin
                        m_pos = (m_pos + 1) % m_len;
                        w = (m_pos == 0);
                    end
                    if (stop) begin
                        m_state = 0; w = 1'b0;
                    end else if (pause) begin
                        m_state = 2;
                    end
                end
                2: if (stop) m_state = 0; else if (pause) m_state = 1;
                default: m_state = 0;
            endcase
            if (m_state == 0) begin
                m_disp = 24'h0; m_blank = 6'h3F;
            end else if (upd) begin
                for (int k = 0; k < 6; k++) begin
                    if (m_len > 6) begin
                        idx = (m_pos + 5 - k) % m_len;
                        m_disp[k*4 +: 4] = m_buf[idx];
                        m_blank[k] = 1'b0;
                    end else if (k >= 6 - m_len) begin
                        m_disp[k*4 +: 4] = m_buf[5 - k];
                        m_blank[k] = 1'b0;
                    end else begin
                        m_disp[k*4 +: 4] = 4'h0;
                        m_blank[k] = 1'b1;
                    end
                end
            end
            if (wr_en) m_buf[wr_addr] = wr_data;
        end
        e.busy  = (m_state != 0);
        e.blank = m_blank;
        e.dig   = m_disp;
        e.wrap  = w;
        q.push_back(e);
    endtask

    // model: samples inputs at the active edge (they change #1 later)
    initial begin
        forever begin
            @(posedge clk);
            model_step();
        end
    end

    // monitor: compare DUT outputs with queued predictions
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("sb_busy",  32'(busy),  32'(e.busy));
                chk("sb_blank", 32'(blank), 32'(e.blank));
                chk("sb_digits", 32'(dig),  32'(e.dig));
                chk("sb_wrap",  32'(wrap_pulse), 32'(e.wrap));
                if (wrap_pulse && e.wrap) wraps_seen++;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wr(input logic [3:0] a, input logic [3:0] d);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        tick(1);
        wr_en = 1'b0;
    endtask

    task automatic do_start(input logic [4:0] l, input logic [1:0] r);
        len = l; rate_sel = r; start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    task automatic pulse_stop();
        stop = 1'b1;
        tick(1);
        stop = 1'b0;
    endtask

    task automatic pulse_pause();
        pause = 1'b1;
        tick(1);
        pause = 1'b0;
    endtask

    initial begin
        reset = 1'b1; wr_en = 1'b0; wr_addr = 4'h0; wr_data = 4'h0;
        len = 5'd0; rate_sel = 2'd0; start = 1'b0; stop = 1'b0; pause = 1'b0;
        tick(2);
        reset = 1'b0;
        chk("reset_busy",  32'(busy),  32'h0);
        chk("reset_blank", 32'(blank), 32'h3F);
        chk("reset_digits", 32'(dig),  32'h0);

        // long message scroll
        for (int i = 0; i < 10; i++) wr(4'(i), 4'(i));
        do_start(5'd10, 2'd0);
        chk("s1_busy", 32'(busy), 32'h1);
        chk("s1_pos0", 32'(dig), 32'h012345);
        chk("s1_blank", 32'(blank), 32'h0);
        tick(4);
        chk("s1_pos1", 32'(dig), 32'h123456);
        tick(24);
        chk("s2_pos7", 32'(dig), 32'h789012);
        tick(20);
        pulse_stop();
        chk("stop_busy", 32'(busy), 32'h0);

        // short static message
        wr(4'd0, 4'hA); wr(4'd1, 4'hB); wr(4'd2, 4'hC);
        do_start(5'd3, 2'd0);
        chk("s3_digits", 32'(dig), 32'hABC000);
        chk("s3_blank", 32'(blank), 32'h07);
        tick(40);
        chk("s3_hold_digits", 32'(dig), 32'hABC000);
        chk("s3_hold_blank", 32'(blank), 32'h07);
        pulse_stop();

        // pause stretches the interval by the paused time
        do_start(5'd10, 2'd2);
        chk("s4_pos0", 32'(dig), 32'hABC345);
        tick(5);
        pulse_pause();
        tick(19);
        pulse_pause();
        tick(5);
        chk("s4_before_step", 32'(dig), 32'hABC345);
        tick(1);
        chk("s4_after_step", 32'(dig), 32'hBC3456);
        pulse_stop();

        // start+stop together, then reset mid-scroll with start
        len = 5'd10; rate_sel = 2'd0; start = 1'b1; stop = 1'b1;
        tick(1);
        start = 1'b0; stop = 1'b0;
        chk("s5_startstop_busy", 32'(busy), 32'h0);
        chk("s5_startstop_blank", 32'(blank), 32'h3F);
        do_start(5'd10, 2'd0);
        tick(7);
        reset = 1'b1; start = 1'b1;
        tick(1);
        reset = 1'b0; start = 1'b0;
        chk("s5_reset_busy", 32'(busy), 32'h0);
        chk("s5_reset_blank", 32'(blank), 32'h3F);
        chk("s5_reset_digits", 32'(dig), 32'h0);

        // illegal length, then write to a displayed address while running
        do_start(5'd0, 2'd0);
        chk("s6_len0_busy", 32'(busy), 32'h0);
        for (int i = 0; i < 10; i++) wr(4'(i), 4'(i));
        do_start(5'd10, 2'd0);
        wr_en = 1'b1; wr_addr = 4'd2; wr_data = 4'hF;
        tick(1);
        wr_en = 1'b0;
        chk("s6_old_value", 32'(d3), 32'h2);
        tick(1);
        chk("s6_new_value", 32'(d3), 32'hF);
        pulse_stop();

        // randomized traffic
        for (int c = 0; c < 1500; c++) begin
            reset    = ($urandom_range(0, 499) == 0);
            wr_en    = ($urandom_range(0, 2) == 0);
            wr_addr  = 4'($urandom_range(0, 15));
            wr_data  = 4'($urandom_range(0, 15));
            start    = ($urandom_range(0, 29) == 0);
            len      = 5'($urandom_range(0, 20));
            rate_sel = 2'($urandom_range(0, 3));
            stop     = ($urandom_range(0, 149) == 0);
            pause    = ($urandom_range(0, 59) == 0);
            tick(1);
        end
        reset = 1'b0; wr_en = 1'b0; start = 1'b0; stop = 1'b0; pause = 1'b0;
        tick(3);
        checks++;
        if (wraps_seen == 0) begin
            errors++;
            $display("FAIL wrap_seen: got %0d wrap pulses expected at least 1", wraps_seen);
        end
        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/hex_scroll_ctrl.md
HEX_SCROLL_CTRL -- requirements
Module: hex_scroll_ctrl

Interface
REQ-001 The block SHALL have parameter TICK_DIV, default 25000000, meaning clock cycles per base scroll tick.
REQ-002 The block SHALL have parameter DEPTH, fixed at 16, meaning message buffer entries of 4 bits each.
REQ-003 The block SHALL use one clock and a synchronous, active-high reset; all state changes occur on the rising edge of clk.
REQ-004 The block SHALL have port clk, input, 1 bit: system clock.
REQ-005 The block SHALL have port reset, input, 1 bit: synchronous active-high reset.
REQ-006 The block SHALL have port wr_en, input, 1 bit: write wr_data into buffer[wr_addr].
REQ-007 The block SHALL have port wr_addr, input, 4 bits: buffer write index.
REQ-008 The block SHALL have port wr_data, input, 4 bits: nibble to store.
REQ-009 The block SHALL have port len, input, 5 bits: message length 1..16, sampled on start.
REQ-010 The block SHALL have port rate_sel, input, 2 bits: step interval of (rate_sel+1) base ticks, sampled on start.
REQ-011 The block SHALL have ports start, stop and pause, each input, 1 bit, single-cycle command pulses.
REQ-012 The block SHALL have port busy, output, 1 bit: high in RUN or PAUSE.
REQ-013 The block SHALL have ports d0..d5, each output, 4 bits: nibble for HEX0..HEX5, where HEX5 is leftmost.
REQ-014 The block SHALL have port blank, output, 6 bits: bit k high means HEXk is blanked.
REQ-015 The block SHALL have port wrap_pulse, output, 1 bit: one-cycle pulse when the window position returns to 0.

Function
REQ-016 The block SHALL implement states IDLE, RUN and PAUSE.
REQ-017 In IDLE, start with len in 1..16 SHALL latch len, rate_sel, set pos=0, clear the prescaler and enter RUN; start with len=0 or len>16 SHALL be ignored.
REQ-018 stop in RUN or PAUSE SHALL return the block to IDLE next cycle; if stop and start are asserted together, stop SHALL win.
REQ-019 pause SHALL toggle RUN to PAUSE or PAUSE to RUN; in PAUSE the prescaler, pos and digit outputs SHALL hold.
REQ-020 start while in RUN or PAUSE SHALL be ignored.
REQ-021 The prescaler SHALL count 0..TICK_DIV-1 in RUN only, with one base tick per wrap; pos SHALL advance after every (rate_sel+1) base ticks.
REQ-022 The first step SHALL occur exactly TICK_DIV*(rate_sel+1) cycles after the start cycle.
REQ-023 If latched len>6, digit HEXk SHALL show buffer[(pos+5-k) mod len], blank=000000, and pos SHALL increment modulo len on each step.
REQ-024 wrap_pulse SHALL be high for the single cycle after pos steps from len-1 to 0.
REQ-025 If latched len<=6, the display SHALL be static: HEX5 down to HEX(6-len) show buffer[0..len-1], the remaining digits are blanked, pos stays 0 and no wrap_pulse is produced.
REQ-026 In IDLE, blank SHALL be 111111, d0..d5 SHALL be 0 and busy SHALL be 0.
REQ-027 All outputs SHALL be registered; busy and valid digits SHALL appear the cycle after start is accepted, and digits SHALL reflect a new pos the cycle after the step.
REQ-028 wr_en SHALL be accepted in any state; a write to a displayed address SHALL appear on the next output update, and same-cycle read/write of one address SHALL show the old value for that cycle.

Reset
REQ-029 Reset SHALL force IDLE with pos=0, prescaler=0, latched len=0 and rate_sel=0, all buffer entries 0, d0..d5=0, blank=111111, busy=0 and wrap_pulse=0.
REQ-030 Reset SHALL take priority over every command, including mid-scroll and same-cycle start.

Verification (TICK_DIV=4 in simulation)
REQ-031 Scenario: write buffer[i]=i for i=0..9, len=10, rate_sel=0, start -> next cycle busy=1 and HEX5..HEX0=0,1,2,3,4,5; after 4 cycles HEX5..HEX0=1..6.
REQ-032 Scenario: continue the previous case for 10 steps -> wrap_pulse high for one cycle as pos goes 9->0; HEX5..HEX0 at pos=7 = 7,8,9,0,1,2.
REQ-033 Scenario: len=3, buffer[0..2]=A,B,C, start -> HEX5..HEX3=A,B,C, blank=000111, and the display is unchanged after 40 cycles.
REQ-034 Scenario: rate_sel=2, pause mid-interval for 20 cycles, then pause again -> the step lands 20 cycles later than the unpaused time of 12 cycles.
REQ-035 Scenario: start and stop asserted in the same cycle, then reset asserted mid-scroll -> the block stays in or returns to IDLE with busy=0 and blank=111111 the following cycle.
REQ-036 Scenario: start with len=0 -> busy stays 0; write during RUN to the address shown on HEX3 -> new value appears on the next output update.
